// File: rtl/interleaver_bit_buffer_pkg.sv
// Shared sizes, FSM state encoding and block-size check for the interleaver bit buffer.
package interleaver_pkg;

  localparam int unsigned K_MIN  = 40;
  localparam int unsigned K_MAX  = 6144;
  localparam int unsigned CNT_W  = 10;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned LANES  = 8;
  localparam int unsigned W_MAX  = K_MAX / LANES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    PERM  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // A block size is usable when it lies in [K_MIN, K_MAX] and is a whole number of bytes.
  function automatic logic k_is_valid(input logic [ADDR_W-1:0] k);
    return (k >= ADDR_W'(K_MIN)) && (k <= ADDR_W'(K_MAX)) && (k[2:0] == 3'd0);
  endfunction

endpackage

// File: rtl/interleaver_bit_buffer_ram.sv
// K_MAX x 1-bit block store: one 8-lane word write port, eight independent
// combinational single-bit read ports.
module interleaver_bit_ram
  import interleaver_pkg::*;
(
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [CNT_W-1:0]        i_wr_addr,
  input  logic [LANES-1:0]        i_wr_data,
  input  logic [LANES*ADDR_W-1:0] i_rd_addr,
  output logic [LANES-1:0]        o_rd_data_c
);

  // Stored as bytes so a natural-order input word is a single entry.
  logic [LANES-1:0] r_mem [W_MAX];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [LANES-1:0]  w_word;

    assign w_addr = i_rd_addr[j*ADDR_W +: ADDR_W];
    assign w_word = r_mem[w_addr[ADDR_W-1:3]];
    // Addresses past the physical store read as zero.
    assign o_rd_data_c[j] = (w_addr < ADDR_W'(K_MAX)) ? w_word[w_addr[2:0]] : 1'b0;
  end

endmodule

// File: rtl/interleaver_bit_buffer.sv
// Stores one natural-order code block, then replays it in QPP order using the
// addresses returned by the external generator (2-cycle fixed latency).
module interleaver_bit_buffer
  import interleaver_pkg::*;
(
  input  logic              clk,
  input  logic              dff_clr,
  input  logic [ADDR_W-1:0] K_i,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [CNT_W-1:0]  cnt_o,
  input  logic [ADDR_W-1:0] pi_0,
  input  logic [ADDR_W-1:0] pi_1,
  input  logic [ADDR_W-1:0] pi_2,
  input  logic [ADDR_W-1:0] pi_3,
  input  logic [ADDR_W-1:0] pi_4,
  input  logic [ADDR_W-1:0] pi_5,
  input  logic [ADDR_W-1:0] pi_6,
  input  logic [ADDR_W-1:0] pi_7,
  output logic              out_valid,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err_k
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_w_last;
  logic [CNT_W-1:0] w_w_last_nxt;
  logic [CNT_W-1:0] r_wr_cnt;
  logic [CNT_W-1:0] w_wr_cnt_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_drain;
  logic             w_drain_nxt;
  logic             w_err_nxt;
  logic             w_we;

  logic             r_v1;
  logic             r_l1;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_err_k;
  logic             r_out_valid;
  logic             r_out_last;
  logic [7:0]       r_out_data;
  logic [7:0]       w_rd_data;

  // State register.
  always_ff @(posedge clk) begin
    if (!dff_clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and counter control; r_w_last holds W-1 for the latched K.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_cnt_nxt = r_wr_cnt;
    w_cnt_nxt    = r_cnt;
    w_drain_nxt  = r_drain;
    w_w_last_nxt = r_w_last;
    w_err_nxt    = 1'b0;
    w_we         = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (start) begin
          if (k_is_valid(K_i)) begin
            w_state_nxt  = LOAD;
            w_wr_cnt_nxt = '0;
            w_w_last_nxt = CNT_W'(K_i[ADDR_W-1:3]) - CNT_W'(1);
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      LOAD: begin
        if (in_valid) begin
          w_we         = 1'b1;
          w_wr_cnt_nxt = r_wr_cnt + CNT_W'(1);
          if (r_wr_cnt == r_w_last) begin
            w_state_nxt = PERM;
            w_cnt_nxt   = '0;
          end
        end
      end
      PERM: begin
        if (r_cnt == r_w_last) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = '0;
          w_drain_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      DRAIN: begin
        w_cnt_nxt   = '0;
        w_drain_nxt = 1'b1;
        if (r_drain) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Counters, registered outputs and the two-stage valid/last pipeline.
  always_ff @(posedge clk) begin
    if (!dff_clr) begin
      r_wr_cnt    <= '0;
      r_cnt       <= '0;
      r_drain     <= 1'b0;
      r_w_last    <= '0;
      r_v1        <= 1'b0;
      r_l1        <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_err_k     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_wr_cnt    <= w_wr_cnt_nxt;
      r_cnt       <= w_cnt_nxt;
      r_drain     <= w_drain_nxt;
      r_w_last    <= w_w_last_nxt;
      r_in_ready  <= (w_state_nxt == LOAD);
      r_busy      <= (w_state_nxt != IDLE);
      r_err_k     <= w_err_nxt;
      r_v1        <= (r_state == PERM);
      r_l1        <= (r_state == PERM) && (r_cnt == r_w_last);
      r_out_valid <= r_v1;
      r_out_last  <= r_l1;
      r_out_data  <= r_v1 ? w_rd_data : 8'h00;
    end
  end

  interleaver_bit_ram u_ram (
    .clk         (clk),
    .i_we        (w_we & dff_clr),
    .i_wr_addr   (r_wr_cnt),
    .i_wr_data   (in_data),
    .i_rd_addr   ({pi_7, pi_6, pi_5, pi_4, pi_3, pi_2, pi_1, pi_0}),
    .o_rd_data_c (w_rd_data)
  );

  assign in_ready  = r_in_ready;
  assign cnt_o     = r_cnt;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign err_k     = r_err_k;

endmodule

// File: tb/tb_interleaver_bit_buffer.sv
// Bench for interleaver_bit_buffer: drives a behavioural QPP generator and
// compares the interleaved output against c'[i] = c[Pi(i)] computed directly.
module tb_interleaver_bit_buffer;
  import interleaver_pkg::*;

  logic        clk = 1'b0;
  logic        dff_clr;
  logic [12:0] K_i;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [9:0]  cnt_o;
  logic [12:0] pi [8];
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;
  logic        err_k;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     gk = 40;
  longint gf1 = 3;
  longint gf2 = 10;
  int     bad_lane = -1;
  bit     c [K_MAX];

  logic [7:0] q_data [$];
  bit         q_last [$];
  int         q_cyc  [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  interleaver_bit_buffer dut (
    .clk       (clk),
    .dff_clr   (dff_clr),
    .K_i       (K_i),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cnt_o     (cnt_o),
    .pi_0      (pi[0]),
    .pi_1      (pi[1]),
    .pi_2      (pi[2]),
    .pi_3      (pi[3]),
    .pi_4      (pi[4]),
    .pi_5      (pi[5]),
    .pi_6      (pi[6]),
    .pi_7      (pi[7]),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .err_k     (err_k)
  );

  // QPP permutation Pi(i) = (f1*i + f2*i^2) mod K.
  function automatic int qpp(input int i);
    longint v;
    v = (gf1 * i + gf2 * longint'(i) * i) % gk;
    return int'(v);
  endfunction

  // Interleaved index carried by lane j of output word n.
  function automatic int lane_idx(input int n, input int j);
    return 2 * n + (j % 2) + (j / 2) * (gk / 4);
  endfunction

  function automatic logic [7:0] exp_word(input int n);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = (j == bad_lane) ? 1'b0 : c[qpp(lane_idx(n, j))];
    return r;
  endfunction

  // Generator model: addresses for word n appear one cycle after cnt_o = n.
  always @(posedge clk) begin
    for (int j = 0; j < 8; j++)
      pi[j] <= (j == bad_lane) ? 13'd6200 : 13'(qpp(lane_idx(int'(cnt_o), j)));
  end

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      q_data.push_back(out_data);
      q_last.push_back(out_last);
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int k);
    @(negedge clk);
    K_i   = 13'(k);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " in_ready"},  in_ready,  1'b0);
    chk({tag, " cnt_o"},     cnt_o,     10'd0);
    chk({tag, " out_valid"}, out_valid, 1'b0);
    chk({tag, " out_last"},  out_last,  1'b0);
    chk({tag, " busy"},      busy,      1'b0);
  endtask

  task automatic run_block(input int k, input longint f1, input longint f2, input bit gaps,
                           input bit repulse, input int rst_at, input string tag);
    int         w;
    int         perm_cyc;
    int         n_last;
    logic [7:0] word;
    w   = k / 8;
    gk  = k;
    gf1 = f1;
    gf2 = f2;
    q_data.delete();
    q_last.delete();
    q_cyc.delete();

    pulse_start(k);
    chk({tag, " busy after start"}, busy, 1'b1);
    for (int m = 0; m < w; m++) begin
      if (gaps) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      chk({tag, " in_ready during load"}, in_ready, 1'b1);
      for (int j = 0; j < 8; j++) word[j] = c[8 * m + j];
      in_valid = 1'b1;
      in_data  = word;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    perm_cyc = cyc;
    chk({tag, " in_ready dropped"}, in_ready, 1'b0);

    for (int i = 0; i < w + 2; i++) begin
      chk({tag, " cnt_o sweep"}, cnt_o, (i < w) ? 10'(i) : 10'd0);
      chk({tag, " busy in perm/drain"}, busy, 1'b1);
      if (rst_at >= 0 && i == rst_at) begin
        dff_clr = 1'b0;
        @(negedge clk);
        check_idle_outputs({tag, " after reset"});
        dff_clr = 1'b1;
        repeat (4) @(negedge clk);
        chk({tag, " words before reset"}, q_data.size(), 1);
        n_last = 0;
        foreach (q_last[x]) if (q_last[x]) n_last++;
        chk({tag, " no out_last"}, n_last, 0);
        check_idle_outputs({tag, " idle after reset"});
        return;
      end
      if (repulse && i == 1) begin
        K_i   = 13'd64;
        start = 1'b1;
      end else begin
        start = 1'b0;
        K_i   = 13'(k);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " busy back to idle"}, busy, 1'b0);
    repeat (3) @(negedge clk);

    chk({tag, " word count"}, q_data.size(), w);
    foreach (q_data[n]) begin
      if (n < w) begin
        chk($sformatf("%s data word %0d", tag, n), q_data[n], exp_word(n));
        chk($sformatf("%s last word %0d", tag, n), q_last[n], (n == w - 1));
        chk($sformatf("%s timing word %0d", tag, n), q_cyc[n], perm_cyc + 2 + n);
      end
    end
  endtask

  initial begin
    int k;
    dff_clr  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    K_i      = 13'd0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    chk("reset out_data", out_data, 8'h00);
    chk("reset err_k", err_k, 1'b0);
    dff_clr = 1'b1;

    // Single-bit tracking: only c[13] set, Pi(1)=13 for K=40.
    foreach (c[i]) c[i] = 1'b0;
    c[13] = 1'b1;
    run_block(40, 3, 10, 1'b0, 1'b0, -1, "single");
    if (q_data.size() > 0) chk("single word0 literal", q_data[0], 8'h02);

    // Unsupported block sizes.
    q_data.delete();
    foreach (q_data[i]) q_data.delete(i);
    pulse_start(41);
    chk("bad K 41 err_k", err_k, 1'b1);
    chk("bad K 41 busy", busy, 1'b0);
    chk("bad K 41 in_ready", in_ready, 1'b0);
    @(negedge clk);
    chk("bad K 41 err_k pulse", err_k, 1'b0);
    pulse_start(6152);
    chk("bad K 6152 err_k", err_k, 1'b1);
    chk("bad K 6152 busy", busy, 1'b0);
    @(negedge clk);
    chk("bad K 6152 err_k pulse", err_k, 1'b0);
    pulse_start(32);
    chk("bad K 32 err_k", err_k, 1'b1);
    @(negedge clk);
    chk("bad K no output", q_data.size(), 0);

    // Same block with input gaps.
    run_block(40, 3, 10, 1'b1, 1'b0, -1, "gaps");

    // Random data, start re-pulsed mid-PERM.
    foreach (c[i]) c[i] = 1'($urandom_range(0, 1));
    run_block(40, 3, 10, 1'b0, 1'b1, -1, "repulse");

    // Reset while n=2, then a fresh block.
    run_block(40, 3, 10, 1'b0, 1'b0, 2, "midreset");
    foreach (c[i]) c[i] = 1'($urandom_range(0, 1));
    run_block(40, 3, 10, 1'b0, 1'b0, -1, "after_reset");

    // Random sizes and coefficients; one run with an out-of-range lane address.
    for (int r = 0; r < 4; r++) begin
      foreach (c[i]) c[i] = 1'($urandom_range(0, 1));
      k = 8 * int'($urandom_range(5, 120));
      bad_lane = (r == 3) ? int'($urandom_range(0, 7)) : -1;
      run_block(k, 2 * longint'($urandom_range(0, 200)) + 1, 2 * longint'($urandom_range(0, 200)),
                1'(r % 2), 1'b0, -1, $sformatf("rand%0d_K%0d", r, k));
      bad_lane = -1;
    end

    // Largest block, all ones.
    foreach (c[i]) c[i] = 1'b1;
    run_block(6144, 263, 480, 1'b0, 1'b0, -1, "kmax");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/interleaver_bit_buffer.md
Name: interleaver_bit_buffer

Overview:
- Data-side companion to the QPP address generator (stage 2).
- Accepts one code block of K systematic bits in natural order, 8 bits per cycle, and stores them.
- Drives the generator's counter and receives its 8 permuted addresses per cycle.
- Reads the stored bits at those addresses and emits the interleaved block c'[i] = c[Pi(i)], 8 bits per cycle, in the generator's lane order.

Parameters:
K_MAX, 6144, largest supported block size (buffer depth in bits)
K_MIN, 40, smallest supported block size
CNT_W, 10, width of word counters (covers K_MAX/8 = 768)
ADDR_W, 13, width of bit addresses and K

Ports:
clk  in  1  clock
dff_clr  in  1  reset; synchronous, active-low
K_i  in  13  block size, sampled on start
start  in  1  one-cycle pulse; begins a block when idle
in_valid  in  1  in_data holds 8 valid natural-order bits
in_data  in  8  bit j = c[8m+j] for the m-th accepted word
in_ready  out  1  buffer accepts a word this cycle
cnt_o  out  10  word counter to the generator's counter_r input
pi_0..pi_7  in  13 each  generator outputs for word n, one cycle after cnt_o = n: Pi(2n), Pi(2n+1), Pi(2n+K/4), Pi(2n+K/4+1), Pi(2n+K/2), Pi(2n+K/2+1), Pi(2n+3K/4), Pi(2n+3K/4+1)
out_valid  out  1  out_data valid
out_data  out  8  bit j = c[pi_j] for one word n
out_last  out  1  marks the final word, n = K/8-1
busy  out  1  high when not IDLE
err_k  out  1  one-cycle pulse: start with an unsupported K

Behaviour:
- Clock and reset: one clock, clk. dff_clr is synchronous and active-low.
- Reset values: in_ready=0, cnt_o=0, out_valid=0, out_data=0, out_last=0, busy=0, err_k=0, state=IDLE. Buffer contents are not cleared.
- K validity: K_MIN <= K_i <= K_MAX and K_i[2:0]==0. Let W = K/8.
- FSM states: IDLE, LOAD, PERM, DRAIN.
- IDLE:
  - in_ready=0, cnt_o=0.
  - start with valid K: latch K, wr_cnt=0, go to LOAD.
  - start with invalid K: err_k=1 for one cycle, stay in IDLE.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid: write in_data[j] to bit 8*wr_cnt+j, then wr_cnt++. Gaps in in_valid hold wr_cnt.
  - Accepted word with wr_cnt==W-1: go to PERM with n=0. in_ready drops in the next cycle.
- PERM:
  - in_ready=0, cnt_o=n, n++ each cycle.
  - At n==W-1: go to DRAIN.
- DRAIN:
  - Two cycles, cnt_o=0, then IDLE.
- Pipeline latency, fixed at 2:
  - cnt_o=n in cycle t.
  - pi_* for word n present in cycle t+1; the buffer is read combinationally and the result registered.
  - out_valid/out_data for word n in cycle t+2.
  - A 2-stage valid/last shift register tracks this. out_last=1 only with word W-1. No output backpressure.
- In-range addresses: pi_j >= K never occurs with a correct generator. Read as-is when < K_MAX; reads 0 when >= K_MAX.
- start outside IDLE is ignored; K is not re-latched.
- Reset mid-operation: state returns to IDLE on the next edge and all outputs take reset values. The in-flight block is discarded with no out_last.
- Back-to-back blocks: start is accepted on the first IDLE cycle after DRAIN.

Decomposition:
- Package interleaver_pkg: K_MIN, K_MAX, CNT_W, ADDR_W, and the state enum {IDLE, LOAD, PERM, DRAIN}.
- One sub-module, interleaver_bit_ram:
  - K_MAX x 1-bit storage.
  - One 8-lane write port at word address wr_cnt.
  - Eight independent combinational 1-bit read ports addressed by pi_0..pi_7.
- The top level holds the FSM, counters and output pipeline.

Test Plan:
- Single-bit tracking, K=40 with a real generator (f1=3, f2=10). Load c[13]=1, all other bits 0 (5 words).
  -> word 0 out_data=8'h02 (Pi(1)=13), arriving 2 cycles after PERM entry.
  -> words 1-4 are 8'h00.
  -> out_last on word 4, then IDLE.
- Invalid K: start with K_i=41, then K_i=6152.
  -> err_k pulses once each.
  -> busy=0, in_ready=0, no out_valid.
- Input gaps: K=40 with in_valid low on alternate cycles.
  -> exactly 5 words written.
  -> PERM begins the cycle after the 5th accepted word; output identical to the gap-free run.
- start re-pulsed during PERM with K_i=64.
  -> ignored; 5 words still emitted for K=40.
- Reset mid-PERM: drive dff_clr=0 at n=2.
  -> next cycle out_valid=0, busy=0, cnt_o=0, in_ready=0.
  -> a fresh K=40 block afterwards produces correct output.
- Maximum block, K=6144, all-ones input.
  -> 768 consecutive words of 8'hFF.
  -> out_last only on the 768th word.
  -> cnt_o sweeps 0..767 with no gaps.
